// File: rtl/fu_seq_pkg.sv
// fu_sequencer shared definitions: opcodes, in_word fields, FSM states.
// Optional feature macro: FU_SEQ_ZERO_FLAG_EN (see fu_sequencer.sv).
package fu_seq_pkg;

   localparam int WORD_W = 9;
   localparam int DATA_W = 8;
   localparam int OP_W   = 3;
   localparam int REG_W  = 2;
   localparam int NREGS  = 4;

   localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
   localparam logic [OP_W-1:0] OP_ADDNB   = 3'b001;
   localparam logic [OP_W-1:0] OP_AND     = 3'b010;
   localparam logic [OP_W-1:0] OP_OR      = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR     = 3'b100;
   localparam logic [OP_W-1:0] OP_SHR_ADD = 3'b101;
   localparam logic [OP_W-1:0] OP_ROR_ADD = 3'b110;
   localparam logic [OP_W-1:0] OP_ROL_ADD = 3'b111;

   localparam int OP_MSB = 8;
   localparam int OP_LSB = 6;
   localparam int RD_MSB = 5;
   localparam int RD_LSB = 4;
   localparam int RA_MSB = 3;
   localparam int RA_LSB = 2;
   localparam int RB_MSB = 1;
   localparam int RB_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   function automatic logic [OP_W-1:0] word_op(input logic [WORD_W-1:0] w);
      return w[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [REG_W-1:0] word_rd(input logic [WORD_W-1:0] w);
      return w[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [REG_W-1:0] word_ra(input logic [WORD_W-1:0] w);
      return w[RA_MSB:RA_LSB];
   endfunction

   function automatic logic [REG_W-1:0] word_rb(input logic [WORD_W-1:0] w);
      return w[RB_MSB:RB_LSB];
   endfunction

endpackage

// File: rtl/fu_seq_fifo.sv
// Synchronous instruction FIFO, DEPTH (power of two) x WIDTH.
// Pushes while full and pops while empty are ignored.
module fu_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   // Storage array; contents are don't-care while the slot is not counted.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fu_sequencer.sv
// Issue controller for the 8-bit functional unit: FIFO, 4x8 regfile, IDLE/EXEC/WB.
// Define FU_SEQ_ZERO_FLAG_EN to add the registered zero_flag output.
module fu_sequencer
   import fu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_word,
   output logic              in_ready,
   input  logic              load_valid,
   input  logic [REG_W-1:0]  load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic [OP_W-1:0]   fu_instruction,
   output logic [DATA_W-1:0] fu_a,
   output logic [DATA_W-1:0] fu_b,
   input  logic [DATA_W-1:0] fu_f,
   output logic              result_valid,
   output logic [REG_W-1:0]  result_addr,
   output logic [DATA_W-1:0] result_data,
`ifdef FU_SEQ_ZERO_FLAG_EN
   output logic              busy,
   output logic              zero_flag
`else
   output logic              busy
`endif
);

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] rf [NREGS];
   logic [REG_W-1:0]  rd_q;
   logic [WORD_W-1:0] head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              ld_we;

   fu_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .din   (in_word),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready    = !fifo_full;
   assign load_ready  = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;
   assign result_addr = rd_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and control: a load in IDLE wins over popping the FIFO.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      ld_we   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (load_valid) begin
               ld_we = 1'b1;
            end else if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Register file: direct loads in IDLE, result writeback in WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (ld_we) begin
         rf[load_addr] <= load_data;
      end else if (state_q == ST_WB) begin
         rf[rd_q] <= result_data;
      end
   end

   // Operand capture on pop; FU inputs stay frozen through EXEC and WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fu_instruction <= '0;
         fu_a           <= '0;
         fu_b           <= '0;
         rd_q           <= '0;
      end else if (pop) begin
         fu_instruction <= word_op(head);
         fu_a           <= rf[word_ra(head)];
         fu_b           <= rf[word_rb(head)];
         rd_q           <= word_rd(head);
      end
   end

   // Result capture in EXEC and the one-cycle writeback pulse after WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_data  <= '0;
         result_valid <= 1'b0;
      end else begin
         if (state_q == ST_EXEC) result_data <= fu_f;
         result_valid <= (state_q == ST_WB);
      end
   end

`ifdef FU_SEQ_ZERO_FLAG_EN
   // Zero flag tracks the most recent writeback value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 zero_flag <= 1'b0;
      else if (state_q == ST_WB)  zero_flag <= (result_data == '0);
   end
`endif

endmodule
